// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared state encoding and default geometry for the memory BIST controller
package mem_bist_pkg;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 4;
  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: write seed^addr pattern, read it back and dump it; optional compare via MEM_BIST_COMPARE_EN
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  dump_valid,
  output logic [DATA_WIDTH-1:0] dump_data
);
  state_t                state_d, state_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] seed_d, seed_q;
  logic                  start_ok;
  logic                  last;
  assign start_ok = (state_q == ST_IDLE) && start;
  assign last     = &addr_q;
  // sequence IDLE -> WRITE(N) -> READ(N) -> DRAIN -> DONE; counter wraps naturally at WRITE->READ
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    case (state_q)
      ST_IDLE: begin
        state_d = start ? ST_WRITE : ST_IDLE;
        seed_d  = start ? seed : seed_q;
        addr_d  = '0;
      end
      ST_WRITE: begin
        state_d = last ? ST_READ : ST_WRITE;
        addr_d  = addr_q + 1'b1;
      end
      ST_READ: begin
        state_d = last ? ST_DRAIN : ST_READ;
        addr_d  = last ? addr_q : addr_q + 1'b1;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state, address counter and latched seed
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
    end
  end
  // memory port and dump stream; readback data lags its address by one cycle
  always_comb begin
    mem_we     = state_q == ST_WRITE;
    mem_addr   = (state_q == ST_WRITE || state_q == ST_READ || state_q == ST_DRAIN) ? addr_q : '0;
    mem_wdata  = mem_we ? seed_q ^ DATA_WIDTH'(addr_q) : '0;
    busy       = state_q != ST_IDLE;
    done       = state_q == ST_DONE;
    dump_valid = (state_q == ST_READ && addr_q != '0) || state_q == ST_DRAIN;
    dump_data  = dump_valid ? mem_rdata : '0;
  end
`ifdef MEM_BIST_COMPARE_EN
  logic                  fail_d, fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_d, fail_addr_q, dump_addr;
  // latch only the first mismatching address of a pass; cleared when a pass is launched
  always_comb begin
    dump_addr   = state_q == ST_DRAIN ? addr_q : addr_q - 1'b1;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    if (start_ok) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
    end else if (dump_valid && !fail_q && mem_rdata != (seed_q ^ DATA_WIDTH'(dump_addr))) begin
      fail_d      = 1'b1;
      fail_addr_d = dump_addr;
    end
  end
  // sticky failure record
  always_ff @(posedge clk_2) begin
    if (reset) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
    end
  end
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
`else
  assign fail      = 1'b0;
  assign fail_addr = '0;
`endif
endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb_mem_bist_ctrl: directed checks of mem_bist_ctrl against a 4x4 synchronous RAM model
module tb_mem_bist_ctrl;
`ifdef MEM_BIST_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif
  logic       clk_2 = 1'b0;
  logic       reset, start, fault;
  logic [3:0] seed;
  logic       mem_we, busy, done, fail, dump_valid;
  logic [1:0] mem_addr, fail_addr;
  logic [3:0] mem_wdata, mem_rdata, dump_data;
  logic [3:0] mem [4];
  int         n_tests = 0;
  int         n_fail  = 0;
  always #5 clk_2 = ~clk_2;
  mem_bist_ctrl dut (
    .clk_2(clk_2), .reset(reset), .start(start), .seed(seed),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .dump_valid(dump_valid), .dump_data(dump_data)
  );
  always @(posedge clk_2) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else mem_rdata <= mem[mem_addr] ^ {3'b000, fault && mem_addr == 2'd2};
  end
  task automatic tick;
    @(posedge clk_2);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_pass(input logic [3:0] s, input logic [15:0] exp_dump, input logic flt, input bit repulse);
    logic [15:0] dump;
    int nd, ndone;
    fault = flt;
    seed  = s;
    start = 1'b1;
    tick;
    start = 1'b0;
    seed  = 4'h0;
    check("fail_clr", fail, 0);
    check("wr0", {mem_we, mem_addr, mem_wdata}, {1'b1, 2'd0, s});
    nd = 0;
    ndone = 0;
    dump = 16'h0;
    for (int e = 1; e <= 10; e++) begin
      if (repulse && (e == 3 || e == 6)) start = 1'b1;
      tick;
      start = 1'b0;
      if (e <= 3) check("wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 2'(e), s ^ 4'(e)});
      if (dump_valid) begin
        if (nd < 4) dump[15-4*nd -: 4] = dump_data;
        nd++;
      end
      if (done) ndone++;
      if (e == 9) check("done_at_9", done, 1);
    end
    check("dump_count", nd, 4);
    check("dump_data", dump, exp_dump);
    check("done_count", ndone, 1);
    check("idle_busy", busy, 0);
    check("fail", fail, CMP && flt);
    check("fail_addr", fail_addr, (CMP && flt) ? 2 : 0);
  endtask
  initial begin
    int ndone;
    reset = 1'b1;
    start = 1'b1;
    seed  = 4'hF;
    fault = 1'b0;
    tick;
    tick;
    check("reset_state", {mem_we, mem_addr, mem_wdata, busy, done, fail, fail_addr, dump_valid, dump_data}, 0);
    reset = 1'b0;
    start = 1'b0;
    tick;
    check("idle_after_reset", {busy, mem_we, mem_addr, dump_valid}, 0);
    run_pass(4'h5, 16'h5476, 1'b0, 1'b0);
    run_pass(4'h5, 16'h5466, 1'b1, 1'b0);
    tick;
    tick;
    tick;
    check("fail_hold", fail, CMP);
    check("fail_addr_hold", fail_addr, CMP ? 2 : 0);
    run_pass(4'hA, 16'hAB89, 1'b0, 1'b0);
    run_pass(4'h5, 16'h5476, 1'b0, 1'b1);
    seed  = 4'h5;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    check("abort_state", {mem_we, mem_addr, mem_wdata, busy, done, fail, fail_addr, dump_valid, dump_data}, 0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_pass(4'h3, 16'h3210, 1'b0, 1'b0);
    seed  = 4'h6;
    start = 1'b1;
    ndone = 0;
    for (int i = 0; i <= 11; i++) begin
      tick;
      if (done) ndone++;
    end
    check("held_start_done", ndone, 1);
    check("held_start_relaunch", {busy, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 2'd0, 4'h6});
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (done) ndone++;
    end
    check("relaunch_done", ndone, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
